param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter: WIDTH, default 12, counter/data width in bits, WIDTH >= 2.
REQ-002 Parameter: MAX, default 2**WIDTH-1, highest count value, 1 <= MAX <= 2**WIDTH-1.
REQ-003 Parameter: STEP, default 1, increment/decrement magnitude, 1 <= STEP <= MAX.
REQ-004 Parameter: SAT_MODE, default 0; 0 = wrap modulo MAX+1, 1 = saturate at 0/MAX.
REQ-005 Port: CLK  input  1  single clock, all state changes on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 Port: En  input  1  count enable.
REQ-008 Port: load  input  1  synchronous preload strobe.
REQ-009 Port: loadData  input  WIDTH  preload value.
REQ-010 Port: up_dn  input  1  direction; 1 = up, 0 = down.
REQ-011 Port: ovf_clr  input  1  synchronous clear of sticky overflow flag.
REQ-012 Port: out  output  WIDTH  current count, registered.
REQ-013 Port: tc  output  1  terminal count, combinational from out and up_dn.
REQ-014 Port: wrap  output  1  registered one-cycle pulse for a wrap/saturation event.
REQ-015 Port: ovf  output  1  sticky overflow flag, registered.

Function
REQ-016 Per-edge priority: reset > load > En; with load=0 and En=0, out holds.
REQ-017 load=1: out <= loadData if loadData <= MAX, else out <= MAX (clamp); wrap <= 0; ovf unchanged.
REQ-018 Up count (En=1, up_dn=1, load=0), no boundary: out <= out+STEP, computed in WIDTH+1 bits.
REQ-019 Up, out+STEP > MAX: SAT_MODE=0 -> out <= out+STEP-(MAX+1); SAT_MODE=1 -> out <= MAX.
REQ-020 Down count (En=1, up_dn=0, load=0), out >= STEP: out <= out-STEP.
REQ-021 Down, out < STEP: SAT_MODE=0 -> out <= out+(MAX+1)-STEP; SAT_MODE=1 -> out <= 0.
REQ-022 Boundary event:
  - definition: any edge taking the REQ-019 or REQ-021 branch, including saturate mode when already at MAX/0;
  - wrap is 1 for exactly the cycle after the event edge, 0 otherwise;
  - ovf is set on the same edge.
REQ-023 Consecutive boundary events keep wrap high on consecutive cycles.
REQ-024 ovf_clr=1 clears ovf on the next edge; a boundary event on the same edge wins, so ovf stays 1.
REQ-025 tc = 1 when (up_dn=1 and out==MAX) or (up_dn=0 and out==0), independent of En.
REQ-026 Count and load ignore ovf; no state outside out, wrap, ovf.
REQ-027 out never exceeds MAX in any mode or input sequence.

Reset
REQ-028 reset=0 forces out=0, wrap=0, ovf=0 immediately, without waiting for CLK.
REQ-029 While reset=0: outputs hold reset values; load, En and ovf_clr are ignored.
REQ-030 Reset asserted mid-count or mid-wrap-pulse aborts the operation; no wrap pulse appears after release.
REQ-031 Release: the first rising CLK edge with reset=1 is evaluated normally per REQ-016.

Verification
REQ-032 WIDTH=12, MAX=4095, STEP=1: reset pulse, load 12'h080, then En=1 up 5 cycles -> out=0x080..0x085, wrap=0, ovf=0.
REQ-033 MAX=9, STEP=3, SAT_MODE=0, up from 6:
  - out sequence 6,9,2,5;
  - wrap high only the cycle after the 9->2 edge;
  - ovf=1 afterwards.
REQ-034 MAX=9, STEP=3, SAT_MODE=1, down from 4:
  - out sequence 4,1,0,0;
  - wrap high after each of the two saturating edges;
  - tc=1 while out=0.
REQ-035 load=1, En=1, loadData=12'hFFF with MAX=9 -> out=9 next cycle (load wins, clamped); wrap=0.
REQ-036 ovf=1, ovf_clr=1 on an edge that is also a boundary event -> ovf stays 1; ovf_clr alone next edge -> ovf=0.
REQ-037 reset driven low between clock edges during counting -> out=0, wrap=0, ovf=0 before the next CLK edge; counting resumes from 0 after release.

Source files
------------

// File: rtl/param_counter.sv
// Parameterised up/down counter with preload, wrap or saturate at the boundaries,
// a one-cycle boundary pulse and a sticky overflow flag.
module param_counter #(
  parameter int WIDTH    = 12,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int STEP     = 1,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             En,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  input  logic             up_dn,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // One extra bit so out+STEP and out+(MAX+1) cannot overflow before the compare.
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MODULUS  = (WIDTH+1)'(MAX + 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX);

  logic [WIDTH:0]   out_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_val;
  logic             boundary;

  assign out_ext  = {1'b0, out};
  assign sum      = out_ext + STEP_EXT;
  assign load_val = ({1'b0, loadData} > MAX_EXT) ? MAX_VAL : loadData;
  assign tc       = up_dn ? (out == MAX_VAL) : (out == '0);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    next_count = out;
    boundary   = 1'b0;
    if (up_dn) begin
      if (sum > MAX_EXT) begin
        boundary = 1'b1;
        if (SAT_MODE) next_count = MAX_VAL;
        else          next_count = WIDTH'(sum - MODULUS);
      end else begin
        next_count = WIDTH'(sum);
      end
    end else begin
      if (out_ext < STEP_EXT) begin
        boundary = 1'b1;
        if (SAT_MODE) next_count = '0;
        else          next_count = WIDTH'(out_ext + MODULUS - STEP_EXT);
      end else begin
        next_count = WIDTH'(out_ext - STEP_EXT);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; reset is asynchronous, active low.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      out  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      out  <= load_val;
      wrap <= 1'b0;
      if (ovf_clr) ovf <= 1'b0;
    end else if (En) begin
      out  <= next_count;
      wrap <= boundary;
      // A boundary event on the same edge as a clear keeps the flag set.
      if (boundary)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three configurations share the same stimulus; expected
// states are queued before each edge and compared after it.
module tb_param_counter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        En, load, up_dn, ovf_clr;
  logic [11:0] loadData;

  logic [11:0] out0, out1, out2;
  logic        tc0, tc1, tc2, wrap0, wrap1, wrap2, ovf0, ovf1, ovf2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [11:0] out;
    logic        wrap;
    logic        ovf;
    logic        tc;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  // 0: defaults (MAX=4095, STEP=1); 1: MAX=9 STEP=3 wrap; 2: MAX=9 STEP=3 saturate
  param_counter #(.WIDTH(12)) u_def (
    .CLK(CLK), .reset(reset), .En(En), .load(load), .loadData(loadData),
    .up_dn(up_dn), .ovf_clr(ovf_clr), .out(out0), .tc(tc0), .wrap(wrap0), .ovf(ovf0));

  param_counter #(.WIDTH(12), .MAX(9), .STEP(3), .SAT_MODE(1'b0)) u_wrap (
    .CLK(CLK), .reset(reset), .En(En), .load(load), .loadData(loadData),
    .up_dn(up_dn), .ovf_clr(ovf_clr), .out(out1), .tc(tc1), .wrap(wrap1), .ovf(ovf1));

  param_counter #(.WIDTH(12), .MAX(9), .STEP(3), .SAT_MODE(1'b1)) u_sat (
    .CLK(CLK), .reset(reset), .En(En), .load(load), .loadData(loadData),
    .up_dn(up_dn), .ovf_clr(ovf_clr), .out(out2), .tc(tc2), .wrap(wrap2), .ovf(ovf2));

  task automatic drive(input logic l, input logic e, input logic u, input logic c,
                       input logic [11:0] d);
    load = l; En = e; up_dn = u; ovf_clr = c; loadData = d;
  endtask

  // Queue the expected state; tc follows from the expected count and current direction.
  task automatic expect_st(input string name, input int sel, input int o,
                           input logic w, input logic v);
    exp_t e;
    int   max_v;
    max_v  = (sel == 0) ? 4095 : 9;
    e.name = name;
    e.sel  = sel;
    e.out  = 12'(o);
    e.wrap = w;
    e.ovf  = v;
    e.tc   = up_dn ? (o == max_v) : (o == 0);
    sb.push_back(e);
  endtask

  task automatic compare_all();
    exp_t        e;
    logic [11:0] a_out;
    logic        a_wrap, a_ovf, a_tc;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin a_out = out0; a_wrap = wrap0; a_ovf = ovf0; a_tc = tc0; end
        1:       begin a_out = out1; a_wrap = wrap1; a_ovf = ovf1; a_tc = tc1; end
        default: begin a_out = out2; a_wrap = wrap2; a_ovf = ovf2; a_tc = tc2; end
      endcase
      checks++;
      if (a_out !== e.out) begin
        errors++;
        $display("FAIL %s dut%0d out: got %0d expected %0d", e.name, e.sel, a_out, e.out);
      end
      checks++;
      if (a_wrap !== e.wrap) begin
        errors++;
        $display("FAIL %s dut%0d wrap: got %b expected %b", e.name, e.sel, a_wrap, e.wrap);
      end
      checks++;
      if (a_ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s dut%0d ovf: got %b expected %b", e.name, e.sel, a_ovf, e.ovf);
      end
      checks++;
      if (a_tc !== e.tc) begin
        errors++;
        $display("FAIL %s dut%0d tc: got %b expected %b", e.name, e.sel, a_tc, e.tc);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  // Pulse reset between edges and confirm all outputs clear without a clock edge.
  task automatic do_reset(input string name);
    reset = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) expect_st(name, s, 0, 1'b0, 1'b0);
    compare_all();
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    #2;
    for (int s = 0; s < 3; s++) expect_st("reset_async", s, 0, 1'b0, 1'b0);
    compare_all();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h005);
    for (int s = 0; s < 3; s++) expect_st("reset_hold", s, 0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic test_load_count();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 12'h080);
    expect_st("load_080", 0, 'h080, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    for (int i = 1; i <= 5; i++) begin
      expect_st("count_up", 0, 'h080 + i, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic test_wrap_mode();
    do_reset("wrap_pre_reset");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 12'd6);
    expect_st("wrap_load6", 1, 6, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
    expect_st("wrap_to9", 1, 9, 1'b0, 1'b0);
    tick();
    expect_st("wrap_9to2", 1, 2, 1'b1, 1'b1);
    tick();
    expect_st("wrap_to5", 1, 5, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
  endtask

  task automatic test_sat_mode();
    do_reset("sat_pre_reset");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'd4);
    expect_st("sat_load4", 2, 4, 1'b0, 1'b0);
    expect_st("dnwrap_load4", 1, 4, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
    expect_st("sat_4to1", 2, 1, 1'b0, 1'b0);
    expect_st("dnwrap_4to1", 1, 1, 1'b0, 1'b0);
    tick();
    expect_st("sat_1to0", 2, 0, 1'b1, 1'b1);
    expect_st("dnwrap_1to8", 1, 8, 1'b1, 1'b1);
    tick();
    expect_st("sat_0to0", 2, 0, 1'b1, 1'b1);
    expect_st("dnwrap_8to5", 1, 5, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    expect_st("sat_hold0", 2, 0, 1'b0, 1'b1);
    expect_st("dnwrap_hold5", 1, 5, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_load_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF);
    expect_st("load_clamp_wrap", 1, 9, 1'b0, 1'b1);
    expect_st("load_clamp_sat", 2, 9, 1'b0, 1'b1);
    expect_st("load_fff_def", 0, 'hFFF, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_ovf_clr();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12'd0);
    expect_st("clr_vs_event_wrap", 1, 2, 1'b1, 1'b1);
    expect_st("clr_vs_event_sat", 2, 9, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'd0);
    expect_st("clr_alone_wrap", 1, 2, 1'b0, 1'b0);
    expect_st("clr_alone_sat", 2, 9, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
    expect_st("run_to5", 1, 5, 1'b0, 1'b0);
    tick();
    expect_st("run_to8", 1, 8, 1'b0, 1'b0);
    tick();
    expect_st("run_8to1", 1, 1, 1'b1, 1'b1);
    tick();
    #3;
    do_reset("midpulse_reset");
    expect_st("resume_wrap", 1, 3, 1'b0, 1'b0);
    expect_st("resume_sat", 2, 3, 1'b0, 1'b0);
    expect_st("resume_def", 0, 1, 1'b0, 1'b0);
    tick();
    expect_st("resume_wrap2", 1, 6, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_count();
    test_wrap_mode();
    test_sat_mode();
    test_load_priority();
    test_ovf_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
